// File: rtl/bdi_pkg.sv
// bdi_pkg: shared constants and types for the BDI decompressor slice.
// Holds the compression mode encodings, the B4D1 delta layout, the
// controller state type and a saturating-increment helper used by the
// optional statistics counters.
package bdi_pkg;

    localparam int WORD_WIDTH     = 32;
    localparam int DATA_FIELD     = 8 * WORD_WIDTH;
    localparam int PAIR_WORDS     = 16;
    localparam int DELTA_BASE_OFS = 32;
    localparam int DELTA_W        = 8;

    typedef logic [7:0] bdi_mode_t;

    localparam bdi_mode_t MODE_RAW  = 8'h00;
    localparam bdi_mode_t MODE_ZERO = 8'h01;
    localparam bdi_mode_t MODE_REP  = 8'h02;
    localparam bdi_mode_t MODE_B4D1 = 8'h04;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        BURST
    } dec_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/bdi_decompressor_if.sv
// bdi_decompressor_if: request/response handshake bundle of the decompressor.
//   in_*  : request side (valid/ready, entry data, mode, base select, address, burst)
//   out_* : response side (valid/ready, word, index, last, err)
// Modports: master = requester/consumer (testbench or upstream), slave = decompressor.
interface bdi_decompressor_if;
    import bdi_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_FIELD-1:0] in_data;
    bdi_mode_t             in_mode;
    logic [31:0]           in_base_one_hot;
    logic [3:0]            in_word_addr;
    logic                  in_burst;

    logic                  out_valid;
    logic                  out_ready;
    logic [WORD_WIDTH-1:0] out_word;
    logic [3:0]            out_word_idx;
    logic                  out_last;
    logic                  out_err;

    modport master (
        output in_valid, in_data, in_mode, in_base_one_hot, in_word_addr, in_burst,
        output out_ready,
        input  in_ready,
        input  out_valid, out_word, out_word_idx, out_last, out_err
    );

    modport slave (
        input  in_valid, in_data, in_mode, in_base_one_hot, in_word_addr, in_burst,
        input  out_ready,
        output in_ready,
        output out_valid, out_word, out_word_idx, out_last, out_err
    );

endinterface

// File: rtl/bdi_word_extract.sv
// bdi_word_extract: combinational reconstruction of one word from a
// compressed entry.
//   data  in  256  compressed entry
//   mode  in  8    compression mode
//   bohot in  16   per-word implicit-zero-base select
//   idx   in  4    word index within the pair
//   word  out 32   reconstructed word (0 when err)
//   err   out 1    illegal mode, or RAW index beyond the stored 8 words
module bdi_word_extract
    import bdi_pkg::*;
(
    input  logic [DATA_FIELD-1:0] data,
    input  bdi_mode_t             mode,
    input  logic [15:0]           bohot,
    input  logic [3:0]            idx,
    output logic [WORD_WIDTH-1:0] word,
    output logic                  err
);

    logic [7:0]            lsb_raw;
    logic [7:0]            lsb_delta;
    logic [DELTA_W-1:0]    delta;
    logic [WORD_WIDTH-1:0] base;

    assign lsb_raw   = {idx[2:0], 5'b0};
    assign lsb_delta = 8'(DELTA_BASE_OFS) + {1'b0, idx, 3'b0};
    assign delta     = data[lsb_delta +: DELTA_W];
    assign base      = data[WORD_WIDTH-1:0];

    always_comb begin
        word = '0;
        err  = 1'b0;
        case (mode)
            MODE_RAW: begin
                if (idx[3]) err = 1'b1;
                else        word = data[lsb_raw +: WORD_WIDTH];
            end
            MODE_ZERO: word = '0;
            MODE_REP:  word = base;
            MODE_B4D1: word = (bohot[idx] ? '0 : base)
                              + {{(WORD_WIDTH-DELTA_W){delta[DELTA_W-1]}}, delta};
            default:   err = 1'b1;
        endcase
    end

endmodule

// File: rtl/bdi_decompressor.sv
// bdi_decompressor: reconstructs words from a stored BDI-compressed entry.
// A request is captured into a stage register, decoded through
// bdi_word_extract and registered at the output: first word two cycles
// after acceptance. Burst requests then step one index per output handshake.
// Ports:
//   clk  in  clock
//   rst  in  asynchronous active-low reset
//   bus  slave modport of bdi_decompressor_if (request + response handshakes)
//   stat_raw/zero/rep/b4d1/err  out 32  per-mode accepted-request counters
//                                       (present only with BDI_STATS_EN defined)
//
// state | meaning
// IDLE  | waiting for a request; in_ready asserted
// LOAD  | entry held in stage register, first word being registered
// BURST | output word presented; index advances on each handshake
module bdi_decompressor
    import bdi_pkg::*;
(
    input  logic clk,
    input  logic rst,
    bdi_decompressor_if.slave bus
`ifdef BDI_STATS_EN
    ,
    output logic [31:0] stat_raw,
    output logic [31:0] stat_zero,
    output logic [31:0] stat_rep,
    output logic [31:0] stat_b4d1,
    output logic [31:0] stat_err
`endif
);

    dec_state_t            state;
    logic                  rdy_en;
    logic [DATA_FIELD-1:0] stg_data;
    bdi_mode_t             stg_mode;
    logic [15:0]           stg_bohot;
    logic [3:0]            stg_idx;
    logic                  stg_burst;

    logic                  out_valid_q;
    logic [WORD_WIDTH-1:0] out_word_q;
    logic [3:0]            out_idx_q;
    logic                  out_last_q;
    logic                  out_err_q;

    logic                  accept;
    logic                  hs;
    logic                  load_out;
    logic                  last_beat;
    logic [3:0]            ext_idx;
    logic [WORD_WIDTH-1:0] ext_word;
    logic                  ext_err;
    logic                  unused_bohot_hi;

    assign unused_bohot_hi = ^bus.in_base_one_hot[31:16];

    // rdy_en keeps in_ready low for the first cycle out of reset.
    assign bus.in_ready = rdy_en && (state == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign hs           = out_valid_q && bus.out_ready;

    // In BURST the extractor looks one index ahead so the next word is ready
    // to be registered on the same edge as the current handshake.
    assign ext_idx   = (state == BURST) ? stg_idx + 4'd1 : stg_idx;
    assign load_out  = (state == LOAD) || ((state == BURST) && hs && !out_last_q);
    assign last_beat = ext_err || !stg_burst
                       || (ext_idx == ((stg_mode == MODE_RAW) ? 4'd7 : 4'd15));

    bdi_word_extract u_extract (
        .data  (stg_data),
        .mode  (stg_mode),
        .bohot (stg_bohot),
        .idx   (ext_idx),
        .word  (ext_word),
        .err   (ext_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rdy_en      <= 1'b0;
            stg_data    <= '0;
            stg_mode    <= MODE_RAW;
            stg_bohot   <= '0;
            stg_idx     <= '0;
            stg_burst   <= 1'b0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            rdy_en <= 1'b1;

            if (load_out) begin
                out_valid_q <= 1'b1;
                out_word_q  <= ext_word;
                out_idx_q   <= ext_idx;
                out_last_q  <= last_beat;
                out_err_q   <= ext_err;
            end else if (hs) begin
                out_valid_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        stg_data  <= bus.in_data;
                        stg_mode  <= bus.in_mode;
                        stg_bohot <= bus.in_base_one_hot[15:0];
                        stg_idx   <= bus.in_burst ? 4'd0 : bus.in_word_addr;
                        stg_burst <= bus.in_burst;
                        state     <= LOAD;
                    end
                end
                LOAD: state <= BURST;
                BURST: begin
                    if (hs) begin
                        if (out_last_q) state <= IDLE;
                        else            stg_idx <= ext_idx;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_word     = out_word_q;
    assign bus.out_word_idx = out_idx_q;
    assign bus.out_last     = out_last_q;
    assign bus.out_err      = out_err_q;

`ifdef BDI_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_raw  <= '0;
            stat_zero <= '0;
            stat_rep  <= '0;
            stat_b4d1 <= '0;
            stat_err  <= '0;
        end else if (accept) begin
            case (bus.in_mode)
                MODE_RAW:  stat_raw  <= sat_inc(stat_raw);
                MODE_ZERO: stat_zero <= sat_inc(stat_zero);
                MODE_REP:  stat_rep  <= sat_inc(stat_rep);
                MODE_B4D1: stat_b4d1 <= sat_inc(stat_b4d1);
                default:   stat_err  <= sat_inc(stat_err);
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_bdi_decompressor.sv
// tb_bdi_decompressor: directed self-checking bench for bdi_decompressor
// (default build, BDI_STATS_EN undefined).
module tb_bdi_decompressor;
    import bdi_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bdi_decompressor_if bus();

    bdi_decompressor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [255:0] d_b4d1;
    logic [255:0] d_raw;
    logic [255:0] d_rep;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request, waits (bounded) for in_ready, and checks the
    // two-cycle latency to out_valid.
    task automatic send(input logic [255:0] d, input logic [7:0] m, input logic [31:0] bh,
                        input logic [3:0] a, input logic b);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("in_ready_before_req", {31'b0, bus.in_ready}, 32'd1);
        bus.in_valid        = 1'b1;
        bus.in_data         = d;
        bus.in_mode         = m;
        bus.in_base_one_hot = bh;
        bus.in_word_addr    = a;
        bus.in_burst        = b;
        step();
        bus.in_valid = 1'b0;
        chk("latency_n1_no_valid", {31'b0, bus.out_valid}, 32'd0);
        step();
        chk("latency_n2_valid", {31'b0, bus.out_valid}, 32'd1);
    endtask

    task automatic beat(input string tag, input logic [31:0] w, input logic [3:0] idx,
                        input logic last, input logic err);
        chk({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
        chk({tag, "_word"},  bus.out_word, w);
        chk({tag, "_idx"},   {28'b0, bus.out_word_idx}, {28'b0, idx});
        chk({tag, "_last"},  {31'b0, bus.out_last}, {31'b0, last});
        chk({tag, "_err"},   {31'b0, bus.out_err}, {31'b0, err});
    endtask

    function automatic logic [31:0] b4d1_exp(input logic [255:0] d, input int i, input logic zb);
        logic [7:0] dl;
        dl = d[32 + 8*i +: 8];
        return (zb ? 32'h0 : d[31:0]) + {{24{dl[7]}}, dl};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid        = 1'b0;
        bus.in_data         = '0;
        bus.in_mode         = MODE_RAW;
        bus.in_base_one_hot = '0;
        bus.in_word_addr    = '0;
        bus.in_burst        = 1'b0;
        bus.out_ready       = 1'b1;

        d_b4d1 = '0;
        d_b4d1[31:0] = 32'h1000_0000;
        for (int i = 0; i < 16; i++) d_b4d1[32 + 8*i +: 8] = (i == 5) ? 8'hFF : 8'(i);
        d_raw = {256{1'b1}};
        for (int i = 0; i < 8; i++) d_raw[32*i +: 32] = 32'hA0 + i;
        d_rep = {8{32'h5A5A_1234}};
        d_rep[31:0] = 32'hDEAD_BEEF;

        // reset state
        repeat (3) step();
        chk("rst_in_ready",  {31'b0, bus.in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_out_word",  bus.out_word, 32'd0);
        chk("rst_out_idx",   {28'b0, bus.out_word_idx}, 32'd0);
        chk("rst_out_last",  {31'b0, bus.out_last}, 32'd0);
        chk("rst_out_err",   {31'b0, bus.out_err}, 32'd0);
        rst = 1'b1;
        step();
        chk("ready_after_rst", {31'b0, bus.in_ready}, 32'd1);

        // single B4D1 with negative delta
        send(d_b4d1, MODE_B4D1, 32'h0, 4'd5, 1'b0);
        beat("b4d1_single", 32'h0FFF_FFFF, 4'd5, 1'b1, 1'b0);
        step();
        chk("b4d1_single_drained", {31'b0, bus.out_valid}, 32'd0);

        // implicit zero base for word 5
        send(d_b4d1, MODE_B4D1, 32'h0000_0020, 4'd5, 1'b0);
        beat("b4d1_zero_base", 32'hFFFF_FFFF, 4'd5, 1'b1, 1'b0);
        step();

        // upper base-select bits are ignored
        send(d_b4d1, MODE_B4D1, 32'hFFFF_0000, 4'd3, 1'b0);
        beat("b4d1_bohot_hi", 32'h1000_0003, 4'd3, 1'b1, 1'b0);
        step();

        // RAW burst with alternating stalls
        send(d_raw, MODE_RAW, 32'h0, 4'd0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            beat("raw_burst", 32'hA0 + i, 4'(i), i == 7, 1'b0);
            chk("raw_burst_in_ready", {31'b0, bus.in_ready}, 32'd0);
            bus.out_ready = 1'b0;
            step();
            beat("raw_burst_stall", 32'hA0 + i, 4'(i), i == 7, 1'b0);
            bus.out_ready = 1'b1;
            step();
        end
        chk("raw_burst_end_valid", {31'b0, bus.out_valid}, 32'd0);

        // REP burst, 16 beats
        send(d_rep, MODE_REP, 32'h0, 4'd0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            beat("rep_burst", 32'hDEAD_BEEF, 4'(i), i == 15, 1'b0);
            chk("rep_burst_in_ready", {31'b0, bus.in_ready}, 32'd0);
            step();
        end
        chk("rep_burst_end_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rep_burst_end_ready", {31'b0, bus.in_ready}, 32'd1);

        // RAW single, ZERO single
        send(d_raw, MODE_RAW, 32'h0, 4'd2, 1'b0);
        beat("raw_single", 32'h0000_00A2, 4'd2, 1'b1, 1'b0);
        step();
        send(d_rep, MODE_ZERO, 32'h0, 4'd7, 1'b0);
        beat("zero_single", 32'h0, 4'd7, 1'b1, 1'b0);
        step();

        // errors
        send(d_raw, 8'h06, 32'h0, 4'd3, 1'b0);
        beat("illegal_single", 32'h0, 4'd3, 1'b1, 1'b1);
        step();
        send(d_raw, 8'h06, 32'h0, 4'd0, 1'b1);
        beat("illegal_burst", 32'h0, 4'd0, 1'b1, 1'b1);
        step();
        chk("illegal_burst_one_beat", {31'b0, bus.out_valid}, 32'd0);
        send(d_raw, MODE_RAW, 32'h0, 4'd9, 1'b0);
        beat("raw_idx9", 32'h0, 4'd9, 1'b1, 1'b1);
        step();

        // reset during beat 4 of a B4D1 burst
        send(d_b4d1, MODE_B4D1, 32'h0, 4'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            beat("b4d1_burst", b4d1_exp(d_b4d1, i, 1'b0), 4'(i), 1'b0, 1'b0);
            if (i < 4) step();
        end
        rst = 1'b0;
        #1;
        chk("midrst_async_valid", {31'b0, bus.out_valid}, 32'd0);
        step();
        chk("midrst_edge_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("midrst_edge_word",  bus.out_word, 32'd0);
        chk("midrst_edge_ready", {31'b0, bus.in_ready}, 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("midrst_no_partial", {31'b0, bus.out_valid}, 32'd0);
        end
        send(d_b4d1, MODE_B4D1, 32'h0, 4'd9, 1'b0);
        beat("after_rst_single", 32'h1000_0009, 4'd9, 1'b1, 1'b0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
